// File: rtl/pwm_multi_pkg.sv
// Shared constants for the multi-channel PWM block: counting modes and
// counter directions.
package pwm_multi_pkg;
   localparam logic MODE_EDGE   = 1'b0;
   localparam logic MODE_CENTER = 1'b1;
   localparam logic DIR_UP      = 1'b0;
   localparam logic DIR_DOWN    = 1'b1;
endpackage

// File: rtl/pwm_prescaler.sv
// Free-running prescaler: tick every 2^sel_clk_i clocks while enabled.
// Reusable by other timers; a sel_clk change acts immediately.
module pwm_prescaler #(
   parameter int CLK_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             s_rst_i,
   input  logic             en_i,
   input  logic [CLK_W-1:0] sel_clk_i,
   output logic             tick_o
);
   localparam int PW = (1 << CLK_W) - 1;

   logic [PW-1:0] cnt_q;
   logic [PW-1:0] cnt_d;
   logic [PW-1:0] mask_s;

   assign mask_s = ~({PW{1'b1}} << sel_clk_i);
   assign tick_o = en_i && ((cnt_q & mask_s) == mask_s);

   always_comb begin
      if (en_i) begin
         cnt_d = cnt_q + PW'(1);
      end else begin
         cnt_d = '0;
      end
   end

   // prescale counter; never reset on tick so the exponent can change on the fly
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (s_rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaler and period counter, double-buffered
// period/duty/mode applied at period boundaries, registered outputs.
module pwm_multi
   import pwm_multi_pkg::*;
#(
   parameter int CHANNELS    = 4,
   parameter int WIDTH       = 8,
   parameter int CLK_W       = 4,
   parameter bit ACTIVE_HIGH = 1'b1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      s_rst_i,
   input  logic                      en_i,
   input  logic [CLK_W-1:0]          sel_clk_i,
   input  logic                      mode_i,
   input  logic [WIDTH-1:0]          period_i,
   input  logic [CHANNELS*WIDTH-1:0] duty_i,
   input  logic                      load_i,
   output logic [CHANNELS-1:0]       pwm_o,
   output logic                      period_end_o,
   output logic                      pending_o
);
   localparam logic INACTIVE = ~ACTIVE_HIGH;

   logic                      tick_s;
   logic                      bnd_s;
   logic                      apply_s;
   logic [WIDTH-1:0]          cnt_q, cnt_d;
   logic [WIDTH-1:0]          top_q, top_d;
   logic                      dir_q, dir_d;
   logic                      mode_q, mode_d;
   logic [CHANNELS*WIDTH-1:0] duty_q, duty_d;
   logic [WIDTH-1:0]          pend_top_q;
   logic                      pend_mode_q;
   logic [CHANNELS*WIDTH-1:0] pend_duty_q;
   logic                      pend_q, pend_d;
   logic                      bnd_q;
   logic                      pe_q;

   pwm_prescaler #(.CLK_W(CLK_W)) u_presc (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .s_rst_i   (s_rst_i),
      .en_i      (en_i),
      .sel_clk_i (sel_clk_i),
      .tick_o    (tick_s)
   );

   always_comb begin
      if (top_q == '0) begin
         bnd_s = tick_s;
      end else if (mode_q == MODE_EDGE) begin
         bnd_s = tick_s && (cnt_q == top_q);
      end else begin
         bnd_s = tick_s && (cnt_q == '0) && (dir_q == DIR_DOWN);
      end
   end

   // disabled counters take pending values at once; running ones wait for a boundary
   assign apply_s = pend_q && (!en_i || bnd_s);
   assign top_d   = apply_s ? pend_top_q  : top_q;
   assign mode_d  = apply_s ? pend_mode_q : mode_q;
   assign duty_d  = apply_s ? pend_duty_q : duty_q;
   assign pend_d  = load_i ? 1'b1 : (apply_s ? 1'b0 : pend_q);

   always_comb begin
      cnt_d = cnt_q;
      dir_d = dir_q;
      if (!en_i) begin
         cnt_d = '0;
         dir_d = DIR_UP;
      end else if (!tick_s) begin
         cnt_d = cnt_q;
      end else if (bnd_s) begin
         dir_d = DIR_UP;
         // center mode resumes at 1: cnt = 0 was already the boundary tick
         if (pend_q || (mode_q == MODE_EDGE) || (top_q == '0)) begin
            cnt_d = '0;
         end else begin
            cnt_d = WIDTH'(1);
         end
      end else if (mode_q == MODE_EDGE) begin
         cnt_d = cnt_q + WIDTH'(1);
      end else if (dir_q == DIR_DOWN) begin
         cnt_d = cnt_q - WIDTH'(1);
      end else if (cnt_q == top_q) begin
         cnt_d = top_q - WIDTH'(1);
         dir_d = DIR_DOWN;
      end else begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q       <= '0;
         dir_q       <= DIR_UP;
         top_q       <= '0;
         mode_q      <= MODE_EDGE;
         duty_q      <= '0;
         pend_q      <= 1'b0;
         pend_top_q  <= '0;
         pend_mode_q <= MODE_EDGE;
         pend_duty_q <= '0;
         bnd_q       <= 1'b0;
         pe_q        <= 1'b0;
      end else if (s_rst_i) begin
         cnt_q       <= '0;
         dir_q       <= DIR_UP;
         top_q       <= '0;
         mode_q      <= MODE_EDGE;
         duty_q      <= '0;
         pend_q      <= 1'b0;
         pend_top_q  <= '0;
         pend_mode_q <= MODE_EDGE;
         pend_duty_q <= '0;
         bnd_q       <= 1'b0;
         pe_q        <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         dir_q  <= dir_d;
         top_q  <= top_d;
         mode_q <= mode_d;
         duty_q <= duty_d;
         pend_q <= pend_d;
         if (load_i) begin
            pend_top_q  <= period_i;
            pend_mode_q <= mode_i;
            pend_duty_q <= duty_i;
         end else begin
            pend_top_q  <= pend_top_q;
            pend_mode_q <= pend_mode_q;
            pend_duty_q <= pend_duty_q;
         end
         // two stages so the pulse lines up with pwm showing the new period
         bnd_q <= en_i && bnd_s;
         pe_q  <= en_i && bnd_q;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic act_s;
      logic pwm_q;

      assign act_s    = en_i && (cnt_q < duty_q[i*WIDTH +: WIDTH]);
      assign pwm_o[i] = pwm_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            pwm_q <= INACTIVE;
         end else if (s_rst_i) begin
            pwm_q <= INACTIVE;
         end else begin
            pwm_q <= act_s ? ~INACTIVE : INACTIVE;
         end
      end
   end

   assign period_end_o = pe_q;
   assign pending_o    = pend_q;
endmodule
